// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the Dmem arbiter: port-owner states and the memlen
// access-length codes used by the MEM stage and the DMA loader.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_IDLE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DMA  = 2'd2
  } owner_e;

  localparam logic [2:0] LEN_B  = 3'd0;
  localparam logic [2:0] LEN_H  = 3'd1;
  localparam logic [2:0] LEN_W  = 3'd2;
  localparam logic [2:0] LEN_BU = 3'd4;
  localparam logic [2:0] LEN_HU = 3'd5;

endpackage

// File: rtl/dmem_arbiter_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the DMA starvation and DMA burst-length counts.
module sat_counter #(
  parameter int MAX = 4,
  localparam int W = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single Dmem port between the MEM stage (priority) and a DMA loader,
// with DMA anti-starvation, a DMA burst cap and a registered DMA read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [2:0]    cpu_len,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [2:0]    dma_len,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic          mem_we,
  output logic [2:0]    mem_len,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX) + 1;
  localparam int BW = $clog2(BURST_MAX) + 1;

  owner_e        last_q;
  owner_e        grant;
  logic          cpu_gnt;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWNER_IDLE;
    end else begin
      last_q <= grant;
    end
  end

  // A running DMA burst keeps the port until its cap; otherwise the CPU wins
  // unless the DMA has waited long enough to be owed a grant.
  always_comb begin
    grant     = OWNER_IDLE;
    mem_we    = 1'b0;
    mem_len   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (last_q == OWNER_DMA && dma_req && burst_cnt < BW'(BURST_MAX)) begin
      grant = OWNER_DMA;
    end else if (cpu_req && starve_cnt < SW'(STARVE_MAX)) begin
      grant = OWNER_CPU;
    end else if (dma_req) begin
      grant = OWNER_DMA;
    end else if (cpu_req) begin
      grant = OWNER_CPU;
    end
    cpu_gnt   = (grant == OWNER_CPU);
    dma_gnt   = (grant == OWNER_DMA);
    cpu_stall = cpu_req && !cpu_gnt;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_len   = cpu_len;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_len   = dma_len;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;

  sat_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dma_req && !dma_gnt),
    .clr (dma_gnt),
    .cnt (starve_cnt)
  );

  sat_counter #(.MAX(BURST_MAX)) u_burst (
    .clk (clk),
    .rst (rst),
    .inc (dma_gnt),
    .clr (!dma_gnt),
    .cnt (burst_cnt)
  );

  // Read data is captured at the edge closing the granted DMA read beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; Dmem is modelled as read data = addr ^ 0xA5A50000.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [2:0]  cpu_len;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [2:0]  dma_len;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [2:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_len(cpu_len), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_len(dma_len), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_len = LEN_W; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_len = LEN_B; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    total += 4;
    if (dma_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%b exp=0", dma_rvalid); end
    if (dma_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h exp=0", dma_rdata); end
    if (dma_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt got=%b exp=0", dma_gnt); end
    if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_only();
    for (int i = 0; i < 10; i++) begin
      cpu_req   = 1'b1;
      cpu_we    = (i == 3);
      cpu_len   = LEN_W;
      cpu_addr  = (i == 3) ? 32'h1001_0000 : 32'h1001_0020;
      cpu_wdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      total += 4;
      if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL cpu_only_stall cyc=%0d got=%b exp=0", i, cpu_stall); end
      if (dma_gnt !== 1'b0) begin bad++; $display("[TB] FAIL cpu_only_dma_gnt cyc=%0d got=%b exp=0", i, dma_gnt); end
      if (mem_we !== (i == 3)) begin bad++; $display("[TB] FAIL cpu_only_mem_we cyc=%0d got=%b exp=%b", i, mem_we, (i == 3)); end
      if (mem_len !== LEN_W) begin bad++; $display("[TB] FAIL cpu_only_mem_len cyc=%0d got=%0d exp=%0d", i, mem_len, LEN_W); end
      if (i == 3) begin
        total += 2;
        if (mem_addr !== 32'h1001_0000) begin bad++; $display("[TB] FAIL cpu_store_addr got=%h exp=10010000", mem_addr); end
        if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL cpu_store_wdata got=%h exp=deadbeef", mem_wdata); end
      end else if (i == 5) begin
        total += 1;
        if (cpu_rdata !== 32'hB5A4_0020) begin bad++; $display("[TB] FAIL cpu_load_rdata got=%h exp=b5a40020", cpu_rdata); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_dma_only();
    logic [31:0] exp_rd [3];
    exp_rd = '{32'hB5A4_0000, 32'hB5A4_0004, 32'hB5A4_0008};
    for (int i = 0; i < 3; i++) begin
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_addr = 32'h1001_0000 + 32'(4 * i);
      #1;
      total += 2;
      if (dma_gnt !== 1'b1) begin bad++; $display("[TB] FAIL dma_only_gnt beat=%0d got=%b exp=1", i, dma_gnt); end
      if (dma_rvalid !== (i > 0)) begin bad++; $display("[TB] FAIL dma_only_rvalid beat=%0d got=%b exp=%b", i, dma_rvalid, (i > 0)); end
      if (i > 0) begin
        total += 1;
        if (dma_rdata !== exp_rd[i-1]) begin bad++; $display("[TB] FAIL dma_only_rdata beat=%0d got=%h exp=%h", i - 1, dma_rdata, exp_rd[i-1]); end
      end
      tick();
    end
    idle_inputs();
    #1;
    total += 2;
    if (dma_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL dma_only_last_rvalid got=%b exp=1", dma_rvalid); end
    if (dma_rdata !== exp_rd[2]) begin bad++; $display("[TB] FAIL dma_only_last_rdata got=%h exp=%h", dma_rdata, exp_rd[2]); end
    tick();
    total += 1;
    if (dma_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL dma_only_rvalid_drop got=%b exp=0", dma_rvalid); end
  endtask

  // Both requesters compete; the DMA wants one beat and drops its request once served.
  task automatic test_contention(input string tag);
    logic dma_pending;
    logic got;
    dma_pending = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h1001_0020;
      dma_req  = dma_pending;
      dma_we   = 1'b0;
      dma_addr = 32'h1001_0040;
      #1;
      total += 2;
      if (dma_gnt !== (c == 4)) begin bad++; $display("[TB] FAIL %s_gnt cyc=%0d got=%b exp=%b", tag, c, dma_gnt, (c == 4)); end
      if (cpu_stall !== (c == 4)) begin bad++; $display("[TB] FAIL %s_stall cyc=%0d got=%b exp=%b", tag, c, cpu_stall, (c == 4)); end
      if (c == 4) begin
        total += 1;
        if (mem_addr !== 32'h1001_0040) begin bad++; $display("[TB] FAIL %s_mem_addr got=%h exp=10010040", tag, mem_addr); end
      end
      if (c == 5) begin
        total += 2;
        if (dma_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL %s_rvalid got=%b exp=1", tag, dma_rvalid); end
        if (dma_rdata !== 32'hB5A4_0040) begin bad++; $display("[TB] FAIL %s_rdata got=%h exp=b5a40040", tag, dma_rdata); end
      end
      got = dma_gnt;
      tick();
      if (got) dma_pending = 1'b0;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst_cap();
    logic cpu_done;
    int   k;
    cpu_done = 1'b0;
    k = 0;
    for (int s = 0; s < 11; s++) begin
      dma_req   = 1'b1;
      dma_we    = 1'b0;
      dma_addr  = 32'h1002_0000 + 32'(4 * k);
      cpu_req   = (s >= 2) && !cpu_done;
      cpu_we    = 1'b1;
      cpu_addr  = 32'h1001_0100;
      cpu_wdata = 32'h1234_5678;
      #1;
      total += 2;
      if (dma_gnt !== (s != 8)) begin bad++; $display("[TB] FAIL burst_gnt slot=%0d got=%b exp=%b", s, dma_gnt, (s != 8)); end
      if (cpu_stall !== (s >= 2 && s < 8)) begin bad++; $display("[TB] FAIL burst_stall slot=%0d got=%b exp=%b", s, cpu_stall, (s >= 2 && s < 8)); end
      if (s == 2) begin
        total += 1;
        if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL burst_dma_mem_we got=%b exp=0", mem_we); end
      end
      if (s == 8) begin
        total += 2;
        if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL burst_cpu_mem_we got=%b exp=1", mem_we); end
        if (mem_wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL burst_cpu_wdata got=%h exp=12345678", mem_wdata); end
      end
      if (cpu_req && !cpu_stall) cpu_done = 1'b1;
      if (dma_gnt) k++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 4; i++) begin
      dma_req  = 1'b1;
      dma_we   = 1'b0;
      dma_addr = 32'h1003_0000 + 32'(4 * i);
      tick();
    end
    total += 1;
    if (dma_rvalid !== 1'b1) begin bad++; $display("[TB] FAIL mid_burst_rvalid got=%b exp=1", dma_rvalid); end
    rst = 1'b0;
    #1;
    total += 2;
    if (dma_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_rvalid got=%b exp=0", dma_rvalid); end
    if (dma_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mid_reset_rdata got=%h exp=0", dma_rdata); end
    idle_inputs();
    tick();
    rst = 1'b1;
    test_contention("post_reset");
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      total += 4;
      if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL idle_mem_we got=%b exp=0", mem_we); end
      if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL idle_mem_addr got=%h exp=0", mem_addr); end
      if (dma_gnt !== 1'b0) begin bad++; $display("[TB] FAIL idle_gnt got=%b exp=0", dma_gnt); end
      if (cpu_stall !== 1'b0) begin bad++; $display("[TB] FAIL idle_stall got=%b exp=0", cpu_stall); end
      tick();
    end
    test_contention("after_idle");
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_contention("contention");
    test_burst_cap();
    test_reset_mid_burst();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
